simon_32_64_core: RTL and testbench
===================================

// Module: simon_32_64_core
// PURPOSE
//  Iterative Simon 32/64 block-cipher engine, one round per clock.
//  Sits directly downstream of the plaintext/key input-collection stage:
//  - its done pulse drives start here;
//  - its 32-bit data and 64-bit key drive pt_in and key_in.
//  Holds the 32-bit ciphertext and flags completion for the output/display stage.
// PARAMETERS
//  ROUNDS  32  number of rounds; 32 = standard Simon 32/64; legal range 1..62
//  Z_SEQ   62'b11111010001001010110000111001101111101000100101011000011100110
//          z0 constant sequence; z[i] = Z_SEQ[61-i]
// PORTS
//  clk       in   1   clock; all logic on rising edge
//  reset     in   1   synchronous, active-high reset
//  start     in   1   one-cycle request; pt_in/key_in sampled in the same cycle
//  pt_in     in   32  plaintext; [31:16] = x (left word), [15:0] = y (right word)
//  key_in    in   64  key; [63:48] = k3, [47:32] = k2, [31:16] = k1, [15:0] = k0
//  ct        out  32  ciphertext {x,y}; updated only on completion, else held
//  ct_valid  out  1   one-cycle pulse, high the cycle after the final round
//  busy      out  1   high while the core is in state RUN
// BEHAVIOUR
//  Reset (clk edge with reset=1):
//   - state = IDLE; x, y, k0..k3, rnd cleared to 0
//   - ct = 0, ct_valid = 0, busy = 0
//   - reset overrides start and aborts any run in progress; no ct_valid follows
//  States:
//   - IDLE: on an edge with start=1, load x/y from pt_in and k0..k3 from key_in;
//     rnd = 0; go to RUN. start=0 keeps IDLE.
//   - RUN: every edge performs one round and advances the key schedule:
//     - f(x) = (rol1(x) & rol8(x)) ^ rol2(x), with rolN = 16-bit left rotate
//     - x <= y ^ f(x) ^ k0;  y <= x
//     - tmp = ror3(k3) ^ k1;  tmp2 = tmp ^ ror1(tmp)
//     - knew = ~k0 ^ tmp2 ^ {15'b0, z[rnd]} ^ 16'h0003
//     - shift k0 <= k1, k1 <= k2, k2 <= k3, k3 <= knew;  rnd <= rnd + 1
//     - on the edge where rnd == ROUNDS-1: ct <= round result {x_next, y_next},
//       ct_valid <= 1, state <= IDLE
//  Timing and width rules:
//   - ct_valid is high exactly ROUNDS cycles after the start-sampling edge,
//     for one cycle; it is 0 in every other cycle
//   - busy = (state == RUN); busy is 0 in the ct_valid cycle
//   - rnd is 6 bits wide; z index = rnd, never exceeding 61
//   - all word arithmetic is 16-bit XOR/AND/NOT; no carries
//  Boundary cases:
//   - start while busy: ignored; inputs not resampled; the run continues unchanged
//   - start in the ct_valid cycle: accepted (state is IDLE), giving back-to-back
//     blocks with no gap
//   - pt_in/key_in changing during RUN: no effect
//   - ct holds its last value until the next completion or reset
//   - keys generated beyond the last round that uses them are computed and
//     discarded
// TESTING
//  1. Reset asserted 3 cycles -> ct = 0, ct_valid = 0, busy = 0;
//     start held high during reset ignored.
//  2. key_in = 64'h1918_1110_0908_0100, pt_in = 32'h6565_6877, 1-cycle start
//     -> busy for 32 cycles; ct_valid pulses at start edge + 32; ct = 32'hC69B_E9BB.
//  3. Vector of test 2; at start edge + 5, pulse start with pt_in = 32'h0
//     -> ignored; still ct = 32'hC69B_E9BB at edge + 32.
//  4. Second start in the ct_valid cycle with the same vector
//     -> second ct_valid exactly 32 cycles later, again ct = 32'hC69B_E9BB.
//  5. Reset at round 17 of a run -> ct = 0, busy = 0, no ct_valid for 40 cycles;
//     a new start then yields the correct ciphertext.
//  6. 200 random pt_in/key_in pairs vs a C/Python Simon 32/64 model
//     -> every ct matches; every ct_valid lands exactly 32 cycles after its start.

Source files
------------

// File: rtl/simon_32_64_core_if.sv
// Request/response bundle between the input-collection stage, the Simon core
// and the output stage.
interface simon_32_64_core_if;
    // start is a one-cycle request with pt_in/key_in qualified by it; it is taken
    // only while busy is low, otherwise dropped. ct_valid is a one-cycle pulse with
    // ct qualified by it; there is no backpressure on either side.
    logic        start;
    logic [31:0] pt_in;
    logic [63:0] key_in;
    logic [31:0] ct;
    logic        ct_valid;
    logic        busy;
    logic        state_dbg;

    modport master (
        output start, pt_in, key_in,
        input  ct, ct_valid, busy, state_dbg
    );

    modport slave (
        input  start, pt_in, key_in,
        output ct, ct_valid, busy, state_dbg
    );
endinterface

// File: rtl/simon_32_64_core.sv
// Iterative Simon 32/64 encryption engine: one round plus one key-schedule
// step per clock, ciphertext held until the next completion or reset.
module simon_32_64_core #(
    parameter int          ROUNDS = 32,
    parameter logic [61:0] Z_SEQ  = 62'b11111010001001010110000111001101111101000100101011000011100110
) (
    input  logic               clk,
    input  logic               reset,
    simon_32_64_core_if.slave  bus
);
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam logic [5:0] LAST_RND = 6'(ROUNDS - 1);

    state_t      state;
    logic [15:0] x, y;
    logic [15:0] k0, k1, k2, k3;
    logic [5:0]  rnd;

    logic [15:0] f_x, x_next;
    logic [15:0] tmp, tmp2, knew;
    logic [5:0]  z_idx;

    // f(x) = (rol1 & rol8) ^ rol2, all 16-bit rotates
    assign f_x    = ({x[14:0], x[15]} & {x[7:0], x[15:8]}) ^ {x[13:0], x[15:14]};
    assign x_next = y ^ f_x ^ k0;

    // Key schedule for m = 4: ror3 of the newest word, mixed with k1
    assign tmp   = {k3[2:0], k3[15:3]} ^ k1;
    assign tmp2  = tmp ^ {tmp[0], tmp[15:1]};
    assign z_idx = 6'd61 - rnd;
    assign knew  = ~k0 ^ tmp2 ^ {15'b0, Z_SEQ[z_idx]} ^ 16'h0003;

    assign bus.state_dbg = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            x            <= '0;
            y            <= '0;
            k0           <= '0;
            k1           <= '0;
            k2           <= '0;
            k3           <= '0;
            rnd          <= '0;
            bus.ct       <= '0;
            bus.ct_valid <= 1'b0;
            bus.busy     <= 1'b0;
        end else begin
            bus.ct_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        x        <= bus.pt_in[31:16];
                        y        <= bus.pt_in[15:0];
                        k0       <= bus.key_in[15:0];
                        k1       <= bus.key_in[31:16];
                        k2       <= bus.key_in[47:32];
                        k3       <= bus.key_in[63:48];
                        rnd      <= '0;
                        state    <= RUN;
                        bus.busy <= 1'b1;
                    end
                end
                RUN: begin
                    x   <= x_next;
                    y   <= x;
                    k0  <= k1;
                    k1  <= k2;
                    k2  <= k3;
                    k3  <= knew;
                    rnd <= rnd + 6'd1;
                    if (rnd == LAST_RND) begin
                        bus.ct       <= {x_next, x};
                        bus.ct_valid <= 1'b1;
                        bus.busy     <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_simon_32_64_core.sv
// Bench for simon_32_64_core: directed vectors plus random blocks checked
// against a key-array Simon 32/64 model through an expected-ciphertext queue.
module tb_simon_32_64_core;
    localparam int          ROUNDS = 32;
    localparam logic [61:0] Z      = 62'b11111010001001010110000111001101111101000100101011000011100110;
    localparam logic [31:0] VEC_PT  = 32'h6565_6877;
    localparam logic [63:0] VEC_KEY = 64'h1918_1110_0908_0100;
    localparam logic [31:0] VEC_CT  = 32'hC69B_E9BB;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    logic [31:0] exp_q[$];
    int          exp_cyc_q[$];

    simon_32_64_core_if bus();

    simon_32_64_core #(.ROUNDS(ROUNDS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running required finished");
        $fatal(1, "timeout");
    end

    // ---------------- reference model ----------------
    function automatic logic [15:0] rol(input logic [15:0] v, input int n);
        return (v << n) | (v >> (16 - n));
    endfunction

    function automatic logic [15:0] ror(input logic [15:0] v, input int n);
        return rol(v, 16 - n);
    endfunction

    function automatic logic [31:0] simon_ref(input logic [31:0] pt, input logic [63:0] key);
        logic [15:0] k[ROUNDS + 4];
        logic [15:0] x, y, t, tmp;
        logic [61:0] z;
        z = Z;
        for (int i = 0; i < 4; i++) k[i] = key[16*i +: 16];
        for (int i = 4; i < ROUNDS; i++) begin
            tmp  = ror(k[i-1], 3) ^ k[i-3];
            tmp  = tmp ^ ror(tmp, 1);
            k[i] = ~k[i-4] ^ tmp ^ {15'b0, z[61-(i-4)]} ^ 16'h0003;
        end
        x = pt[31:16];
        y = pt[15:0];
        for (int i = 0; i < ROUNDS; i++) begin
            t = x;
            x = y ^ ((rol(x, 1) & rol(x, 8)) ^ rol(x, 2)) ^ k[i];
            y = t;
        end
        return {x, y};
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : monitor
        logic [31:0] e;
        int          c;
        if (bus.ct_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("ct_valid_unexpected", 32'(bus.ct_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                c = exp_cyc_q.pop_front();
                check("ct", bus.ct, e);
                check("ct_valid_cycle", 32'(cyc), 32'(c));
                check("busy_in_valid_cycle", 32'(bus.busy), 32'd0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called at a negedge; the following posedge samples start.
    task automatic start_block(input logic [31:0] pt, input logic [63:0] key,
                               input logic [31:0] exp, input bit push);
        bus.pt_in  = pt;
        bus.key_in = key;
        bus.start  = 1'b1;
        if (push) begin
            exp_q.push_back(exp);
            exp_cyc_q.push_back(cyc + 1 + ROUNDS);
        end
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            check(name, 32'(exp_q.size()), 32'd0);
            exp_q.delete();
            exp_cyc_q.delete();
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin : main
        int          b;
        int          t;
        logic [31:0] pt;
        logic [63:0] key;

        // Reset for three cycles with start held high
        reset      = 1'b1;
        bus.start  = 1'b1;
        bus.pt_in  = VEC_PT;
        bus.key_in = VEC_KEY;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ct", bus.ct, 32'd0);
        check("reset_ct_valid", 32'(bus.ct_valid), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        reset     = 1'b0;
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_after_reset_busy", 32'(bus.busy), 32'd0);

        // Known-answer vector and busy duration
        start_block(VEC_PT, VEC_KEY, VEC_CT, 1'b1);
        b = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.busy === 1'b1) b++;
            @(negedge clk);
        end
        check("busy_cycles", 32'(b), 32'(ROUNDS));
        wait_drain("kat_drain");

        // Start while busy is ignored
        @(negedge clk);
        start_block(VEC_PT, VEC_KEY, VEC_CT, 1'b1);
        repeat (4) @(negedge clk);
        start_block(32'h0, VEC_KEY, 32'h0, 1'b0);
        wait_drain("ignored_start_drain");

        // Back-to-back: second start in the ct_valid cycle
        @(negedge clk);
        start_block(VEC_PT, VEC_KEY, VEC_CT, 1'b1);
        t = 0;
        while (bus.ct_valid !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("b2b_first_valid_seen", 32'(bus.ct_valid), 32'd1);
        start_block(VEC_PT, VEC_KEY, VEC_CT, 1'b1);
        wait_drain("b2b_drain");

        // Reset in the middle of a run aborts it
        @(negedge clk);
        start_block(VEC_PT ^ 32'h1, VEC_KEY, 32'h0, 1'b0);
        repeat (17) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_ct", bus.ct, 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_ct_valid", 32'(bus.ct_valid), 32'd0);
        repeat (40) @(negedge clk);
        start_block(VEC_PT, VEC_KEY, VEC_CT, 1'b1);
        wait_drain("after_abort_drain");

        // Random blocks with input noise and ignored starts during RUN
        for (int n = 0; n < 200; n++) begin
            pt  = $urandom;
            key = {$urandom, $urandom};
            @(negedge clk);
            start_block(pt, key, simon_ref(pt, key), 1'b1);
            t = 0;
            while (exp_q.size() != 0 && t < 100) begin
                bus.pt_in  = $urandom;
                bus.key_in = {$urandom, $urandom};
                bus.start  = (bus.busy === 1'b1) && ($urandom_range(0, 3) == 0);
                @(negedge clk);
                t++;
            end
            bus.start = 1'b0;
            if (exp_q.size() != 0) begin
                check("random_timeout", 32'(exp_q.size()), 32'd0);
                exp_q.delete();
                exp_cyc_q.delete();
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        wait_drain("final_drain");
        repeat (5) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
